// File: rtl/winograd_pkg.sv
// -----------------------------------------------------------------------------
// winograd_pkg
// Shared definitions for the Winograd tile I/O serialiser/deserialiser:
//   - default parameter values for the top level and the output serialiser
//   - input-side FSM state encoding (LOAD / WAIT / HOLD)
//   - counter-width helper so every counter is sized from its terminal count
// -----------------------------------------------------------------------------
package winograd_pkg;

    localparam int DEF_N_IN     = 10;
    localparam int DEF_IN_W     = 8;
    localparam int DEF_N_OUT    = 6;
    localparam int DEF_OUT_W    = 10;
    localparam int DEF_CORE_LAT = 2;

    // Input FSM state encoding
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Bits needed to count 0..n-1; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/winograd_out_ser.sv
// -----------------------------------------------------------------------------
// winograd_out_ser
// Single-tile output buffer that serialises a captured parallel result,
// element 0 first, over a valid/ready handshake.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   capture_i         load par_i into the buffer (wins over a same-cycle drain)
//   par_i             parallel result, N_OUT elements of OUT_W bits
//   dout_o            current serial element (registered)
//   dout_valid_o      buffer holds an undrained tile (registered)
//   dout_ready_i      sink accepts dout_o this cycle
//   empty_o           buffer holds nothing
//   drained_o         pulse: last element accepted this cycle
// -----------------------------------------------------------------------------
module winograd_out_ser
    import winograd_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   capture_i,
    input  logic [N_OUT*OUT_W-1:0] par_i,
    output logic [OUT_W-1:0]       dout_o,
    output logic                   dout_valid_o,
    input  logic                   dout_ready_i,
    output logic                   empty_o,
    output logic                   drained_o
);

    localparam int             J_W    = cnt_w(N_OUT);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    logic [N_OUT*OUT_W-1:0] buf_q;
    logic [N_OUT*OUT_W-1:0] buf_d;
    logic [J_W-1:0]         j_q;
    logic [J_W-1:0]         j_d;
    logic [J_W-1:0]         j_inc_s;
    logic                   valid_q;
    logic                   valid_d;
    logic [OUT_W-1:0]       dout_q;
    logic [OUT_W-1:0]       dout_d;
    logic                   fire_s;

    assign fire_s       = valid_q & dout_ready_i;
    assign drained_o    = fire_s & (j_q == J_LAST);
    assign empty_o      = ~valid_q;
    assign j_inc_s      = j_q + 1'b1;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;

    // Next-state: capture refills (even while draining), otherwise advance or empty
    always_comb begin
        buf_d   = buf_q;
        j_d     = j_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        if (capture_i) begin
            buf_d   = par_i;
            j_d     = '0;
            valid_d = 1'b1;
            dout_d  = par_i[OUT_W-1:0];
        end else if (drained_o) begin
            j_d     = '0;
            valid_d = 1'b0;
        end else if (fire_s) begin
            // dout is registered, so the next element is pre-selected here
            j_d     = j_inc_s;
            dout_d  = buf_q[j_inc_s*OUT_W +: OUT_W];
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer, element index and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            j_q     <= j_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: rtl/winograd_io_serdes.sv
// -----------------------------------------------------------------------------
// winograd_io_serdes
// Deserialises a stream of input elements into a parallel tile for a
// fixed-latency Winograd core, captures the core result and serialises it.
// Loading of the next tile overlaps draining of the previous one.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   din/din_valid/din_ready serial input element handshake
//   dout/dout_valid/dout_ready serial output element handshake
//   core_d                  parallel tile to the core (held through WAIT/HOLD)
//   core_z                  parallel core result, valid CORE_LAT cycles after core_d
//   tile_cnt                number of tiles fully drained (wraps)
// -----------------------------------------------------------------------------
module winograd_io_serdes
    import winograd_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int IN_W     = DEF_IN_W,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int CORE_LAT = DEF_CORE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [OUT_W-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [N_IN*IN_W-1:0]   core_d,
    input  logic [N_OUT*OUT_W-1:0] core_z,
    output logic [15:0]            tile_cnt
);

    localparam int               K_W      = cnt_w(N_IN);
    localparam int               LAT_W    = cnt_w(CORE_LAT);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_IN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LAT - 1);

    logic [ST_W-1:0]      state_q;
    logic [ST_W-1:0]      state_d;
    logic [K_W-1:0]       k_q;
    logic [K_W-1:0]       k_d;
    logic [LAT_W-1:0]     lat_q;
    logic [LAT_W-1:0]     lat_d;
    logic [N_IN*IN_W-1:0] core_d_q;
    logic [N_IN*IN_W-1:0] core_d_d;
    logic [15:0]          tile_cnt_q;
    logic [15:0]          tile_cnt_d;
    logic                 in_fire_s;
    logic                 capture_s;
    logic                 empty_s;
    logic                 drained_s;
    logic                 out_free_s;

    assign din_ready  = (state_q == ST_LOAD);
    assign in_fire_s  = din_valid & din_ready;
    // The buffer can take a new tile if it is empty or its last word leaves now
    assign out_free_s = empty_s | drained_s;
    assign core_d     = core_d_q;
    assign tile_cnt   = tile_cnt_q;

    // Input FSM: element loading, core latency wait, hold for a busy output buffer
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        lat_d     = lat_q;
        core_d_d  = core_d_q;
        capture_s = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_fire_s) begin
                    core_d_d[k_q*IN_W +: IN_W] = din;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        lat_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    lat_d = '0;
                    if (out_free_s) begin
                        capture_s = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_free_s) begin
                    capture_s = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                k_d     = '0;
                lat_d   = '0;
            end
        endcase
    end

    // Drained-tile counter, wrapping at 16 bits
    always_comb begin
        if (drained_s) begin
            tile_cnt_d = tile_cnt_q + 16'd1;
        end else begin
            tile_cnt_d = tile_cnt_q;
        end
    end

    // State, counters, input tile and tile count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            k_q        <= '0;
            lat_q      <= '0;
            core_d_q   <= '0;
            tile_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            lat_q      <= lat_d;
            core_d_q   <= core_d_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    winograd_out_ser #(
        .N_OUT (N_OUT),
        .OUT_W (OUT_W)
    ) u_out_ser (
        .clk_i        (clk),
        .rst_i        (rst),
        .capture_i    (capture_s),
        .par_i        (core_z),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .empty_o      (empty_s),
        .drained_o    (drained_s)
    );

endmodule

// File: tb/tb_winograd_io_serdes.sv
// -----------------------------------------------------------------------------
// tb_winograd_io_serdes
// Directed bench for winograd_io_serdes with a queue-based reference model:
// every accepted input element is collected into a tile; a completed tile
// yields N_OUT expected words which must appear on dout in order, and the
// drained-tile count is tracked alongside. A behavioural core model drives
// core_z either with a fixed pattern or a weighted sum of the input tile.
// -----------------------------------------------------------------------------
module tb_winograd_io_serdes;
    import winograd_pkg::*;

    localparam int N_IN  = 10;
    localparam int IN_W  = 8;
    localparam int N_OUT = 6;
    localparam int OUT_W = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [IN_W-1:0]        din = '0;
    logic                   din_valid = 1'b0;
    logic                   din_ready;
    logic [OUT_W-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready = 1'b0;
    logic [N_IN*IN_W-1:0]   core_d;
    logic [N_OUT*OUT_W-1:0] core_z;
    logic [15:0]            tile_cnt;

    logic                   core_mode = 1'b0;   // 0: fixed pattern, 1: weighted sum
    logic                   rand_rdy  = 1'b0;
    logic [OUT_W-1:0]       pat [N_OUT] = '{10'h3FF, 10'h001, 10'h155, 10'h2AA, 10'h000, 10'h200};
    logic [IN_W-1:0]        cd_arr [N_IN];

    // model state
    logic [IN_W-1:0]        part [$];
    logic [OUT_W-1:0]       exp_q [$];
    int                     wcount = 0;
    logic [15:0]            model_cnt = 16'd0;
    logic                   last_acc = 1'b0;
    logic [IN_W-1:0]        tile_b [N_IN];

    int n_chk  = 0;
    int n_pass = 0;

    winograd_io_serdes dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .core_d     (core_d),
        .core_z     (core_z),
        .tile_cnt   (tile_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] core_word(input logic [IN_W-1:0] e [N_IN], input int j);
        logic [31:0] acc;
        acc = 32'd0;
        for (int k = 0; k < N_IN; k++) acc = acc + 32'(e[k]) * 32'(k + 1 + j);
        acc = acc + 32'(j * 7);
        return acc[OUT_W-1:0];
    endfunction

    // behavioural core: result is a pure function of the presented tile
    always_comb begin
        for (int k = 0; k < N_IN; k++) cd_arr[k] = core_d[k*IN_W +: IN_W];
    end

    always_comb begin
        core_z = '0;
        for (int j = 0; j < N_OUT; j++)
            core_z[j*OUT_W +: OUT_W] = core_mode ? core_word(cd_arr, j) : pat[j];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // per-cycle model update and comparison, sampled 2 time units after negedge
    task automatic sample();
        logic [IN_W-1:0] t [N_IN];
        if (rst) begin
            chk("rst_din_ready", {63'd0, din_ready}, 64'd1);
            chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
            chk("rst_dout", {54'd0, dout}, 64'd0);
            chk("rst_core_d", {63'd0, (core_d == '0)}, 64'd1);
            chk("rst_tile_cnt", {48'd0, tile_cnt}, 64'd0);
            part.delete();
            exp_q.delete();
            wcount    = 0;
            model_cnt = 16'd0;
            last_acc  = 1'b0;
        end else begin
            chk("tile_cnt", {48'd0, tile_cnt}, {48'd0, model_cnt});
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("dout_valid_unexpected", {63'd0, dout_valid}, 64'd0);
                end else begin
                    chk("dout_word", {54'd0, dout}, {54'd0, exp_q[0]});
                    if (dout_ready) begin
                        void'(exp_q.pop_front());
                        wcount++;
                        if (wcount == N_OUT) begin
                            wcount    = 0;
                            model_cnt = model_cnt + 16'd1;
                        end
                    end
                end
            end
            last_acc = din_valid & din_ready;
            if (last_acc) begin
                part.push_back(din);
                if (part.size() == N_IN) begin
                    for (int k = 0; k < N_IN; k++) t[k] = part[k];
                    for (int j = 0; j < N_OUT; j++)
                        exp_q.push_back(core_mode ? core_word(t, j) : pat[j]);
                    part.delete();
                end
            end
        end
    endtask

    // one clock cycle: sample current inputs/outputs, advance to next negedge
    task automatic cyc();
        #2;
        sample();
        @(negedge clk);
        if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [IN_W-1:0] v);
        int guard;
        guard     = 0;
        din       = v;
        din_valid = 1'b1;
        forever begin
            cyc();
            if (last_acc) break;
            guard++;
            if (guard > 2000) begin
                chk("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard     = 0;
        din_valid = 1'b0;
        while ((exp_q.size() != 0 || part.size() != 0) && guard < 2000) begin
            cyc();
            guard++;
        end
        chk("drain_in_time", {63'd0, (guard < 2000)}, 64'd1);
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for a few cycles (reset values checked every cycle)
        repeat (3) cyc();

        // tile 1: din = 1..10 back to back, first handshake in the release cycle
        rst        = 1'b0;
        dout_ready = 1'b1;
        core_mode  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            din       = 8'(i + 1);
            din_valid = 1'b1;
            cyc();
        end
        din_valid = 1'b0;
        for (int k = 0; k < N_IN; k++)
            chk($sformatf("core_d_el%0d", k), {56'd0, core_d[k*IN_W +: IN_W]}, 64'(k + 1));
        chk("lat_c1_valid", {63'd0, dout_valid}, 64'd0);
        cyc();
        chk("lat_c2_valid", {63'd0, dout_valid}, 64'd0);
        cyc();
        chk("lat_c3_valid", {63'd0, dout_valid}, 64'd1);
        chk("pat_w0", {54'd0, dout}, 64'h3FF);
        cyc();
        chk("pat_w1", {54'd0, dout}, 64'h001);
        cyc();
        chk("pat_w2", {54'd0, dout}, 64'h155);
        cyc();
        chk("pat_w3", {54'd0, dout}, 64'h2AA);
        cyc();
        chk("pat_w4", {54'd0, dout}, 64'h000);
        cyc();
        chk("pat_w5", {54'd0, dout}, 64'h200);
        cyc();
        chk("pat_done_valid", {63'd0, dout_valid}, 64'd0);
        chk("pat_tile_cnt", {48'd0, tile_cnt}, 64'd1);

        // back-pressure: tile A buffered, tile B loaded and held
        dout_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) send(8'(8'h30 + i));
        repeat (3) cyc();
        chk("a_valid", {63'd0, dout_valid}, 64'd1);
        chk("a_w0", {54'd0, dout}, 64'h3FF);
        core_mode = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            tile_b[i] = 8'(8'h11 * i + 3);
            send(tile_b[i]);
        end
        repeat (3) cyc();
        chk("hold_state", {62'd0, dut.state_q}, {62'd0, ST_HOLD});
        chk("hold_din_ready", {63'd0, din_ready}, 64'd0);
        chk("hold_valid", {63'd0, dout_valid}, 64'd1);
        chk("hold_dout", {54'd0, dout}, 64'h3FF);
        dout_ready = 1'b1;
        repeat (6) cyc();
        chk("release_valid", {63'd0, dout_valid}, 64'd1);
        chk("release_b_w0", {54'd0, dout}, {54'd0, core_word(tile_b, 0)});
        chk("release_din_ready", {63'd0, din_ready}, 64'd1);
        wait_drain();
        chk("after_hold_tile_cnt", {48'd0, tile_cnt}, 64'd3);

        // reset with a buffered tile and a partial tile in flight
        dout_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) send(8'(8'h50 + i));
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) send(8'(8'h70 + i));
        rst = 1'b1;
        repeat (2) cyc();
        rst        = 1'b0;
        dout_ready = 1'b1;
        repeat (20) cyc();
        chk("post_rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("post_rst_tile_cnt", {48'd0, tile_cnt}, 64'd0);
        for (int i = 0; i < N_IN; i++) send(8'($urandom_range(0, 255)));
        wait_drain();
        chk("post_rst_tile_done", {48'd0, tile_cnt}, 64'd1);

        // 100 tiles with random input gaps and random sink stalls
        rand_rdy = 1'b1;
        for (int t = 0; t < 100; t++) begin
            for (int e = 0; e < N_IN; e++) begin
                while ($urandom_range(0, 1) == 1) begin
                    din_valid = 1'b0;
                    cyc();
                end
                send(8'($urandom_range(0, 255)));
            end
        end
        rand_rdy   = 1'b0;
        dout_ready = 1'b1;
        wait_drain();
        chk("random_tile_cnt", {48'd0, tile_cnt}, 64'd101);
        chk("random_queue_empty", 64'(exp_q.size()), 64'd0);

        // tile_cnt wrap from 0xFFFF
        force dut.tile_cnt_q = 16'hFFFF;
        model_cnt = 16'hFFFF;
        cyc();
        release dut.tile_cnt_q;
        cyc();
        chk("preload_tile_cnt", {48'd0, tile_cnt}, 64'hFFFF);
        for (int i = 0; i < N_IN; i++) send(8'(i * 5));
        wait_drain();
        chk("wrap_tile_cnt", {48'd0, tile_cnt}, 64'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/winograd_io_serdes.md
WINOGRAD_IO_SERDES -- requirements
Module: winograd_io_serdes

Interface
REQ-001 SHALL have parameter N_IN, default 10, meaning input-tile element count.
REQ-002 SHALL have parameter IN_W, default 8, meaning input element width in bits.
REQ-003 SHALL have parameter N_OUT, default 6, meaning output-tile element count.
REQ-004 SHALL have parameter OUT_W, default 10, meaning output element width in bits.
REQ-005 SHALL have parameter CORE_LAT, default 2, meaning cycles from stable core_d to valid core_z, with legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port din, input, IN_W bits: serial input element.
REQ-009 SHALL have ports din_valid (input, 1 bit) and din_ready (output, 1 bit): the input handshake.
REQ-010 SHALL have port dout, output, OUT_W bits: serial output element.
REQ-011 SHALL have ports dout_valid (output, 1 bit) and dout_ready (input, 1 bit): the output handshake.
REQ-012 SHALL have port core_d, output, N_IN*IN_W bits: parallel tile driven to the Winograd core.
REQ-013 SHALL have port core_z, input, N_OUT*OUT_W bits: parallel result from the core.
REQ-014 SHALL have port tile_cnt, output, 16 bits: count of tiles fully drained.

Function
REQ-015 Input FSM SHALL have exactly three states: LOAD, WAIT, HOLD.
REQ-016 In LOAD, din_ready SHALL be 1; each cycle with din_valid&din_ready SHALL write din into core_d[k*IN_W +: IN_W], where k is an input counter starting at 0.
REQ-017 On the handshake with k = N_IN-1, k SHALL clear to 0 and the FSM SHALL go to WAIT; din_ready SHALL be 0 in WAIT and HOLD.
REQ-018 WAIT SHALL last exactly CORE_LAT cycles, counted by a latency counter, with core_d held stable throughout.
REQ-019 At WAIT expiry, if the output buffer is empty, or is emptying this same cycle (see REQ-023), core_z SHALL be captured into the output buffer and the FSM SHALL return to LOAD.
REQ-020 At WAIT expiry with the output buffer occupied and not emptying, the FSM SHALL go to HOLD with core_d held; it SHALL capture and return to LOAD on the first cycle the buffer is empty or emptying.
REQ-021 core_d SHALL retain its previous tile values until overwritten element by element in LOAD.
REQ-022 Output side: on capture, dout_valid SHALL be 1 from the next cycle, and dout SHALL present element j = 0 first (core_z[j*OUT_W +: OUT_W]).
REQ-023 Each cycle with dout_valid&dout_ready SHALL advance j; the handshake at j = N_OUT-1 SHALL empty the buffer, clear j to 0, and increment tile_cnt, with tile_cnt wrapping from 0xFFFF to 0.
REQ-024 dout and dout_valid SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-025 Loading of tile n+1 SHALL proceed concurrently with draining of tile n, giving a throughput of one tile per max(N_IN+CORE_LAT, N_OUT) cycles with a ready sink.
REQ-026 Minimum latency, from the last din handshake to the first dout_valid, SHALL be CORE_LAT+1 cycles.

Reset
REQ-027 While rst=1, outputs SHALL be: din_ready=1, dout_valid=0, dout=0, core_d=0, tile_cnt=0; the FSM SHALL be in LOAD and all counters SHALL be 0, applied asynchronously.
REQ-028 Reset asserted mid-tile SHALL discard both the partial input tile and the buffered output; no dout_valid SHALL appear afterwards until a full new tile completes.
REQ-029 Reset release SHALL take effect on the next rising clk; the first din handshake SHALL be possible in that cycle.

Structure
REQ-030 Default parameter values and the FSM state enumeration SHALL live in a shared package, winograd_pkg.
REQ-031 The output buffer and drain logic SHALL be a sub-module, winograd_out_ser, with ports: capture, parallel in, dout/valid/ready, empty, drained-pulse.
REQ-032 Counter widths SHALL be $clog2-derived from N_IN, N_OUT and CORE_LAT.

Verification
REQ-033 Scenario SHALL cover: defaults, din = 1..10 one per cycle -> core_d element k equals k+1; dout_valid rises 3 cycles after the 10th handshake.
REQ-034 Scenario SHALL cover: core model Z = fixed pattern 0x3FF,0x001,0x155,0x2AA,0x000,0x200 with dout_ready=1 -> dout emits those six words in order, then dout_valid=0 and tile_cnt=1.
REQ-035 Scenario SHALL cover: dout_ready=0 held while a second tile is loaded -> FSM enters HOLD, din_ready=0, and dout stays 0x3FF; raising dout_ready completes the drain with capture in the same cycle as the last handshake.
REQ-036 Scenario SHALL cover: rst pulsed after 4 of 10 inputs -> dout_valid never asserts; a subsequent full tile is output correctly with tile_cnt=1.
REQ-037 Scenario SHALL cover: din_valid toggled randomly, 50% duty -> no element lost or duplicated over 100 tiles, checked against the model.
REQ-038 Scenario SHALL cover: tile_cnt preloaded via force to 0xFFFF -> after one tile it reads 0x0000.
